exception_ctrl: RTL
===================

// Module: exception_ctrl
// PURPOSE
//  Collects exception requests from the pipeline (prefetch abort, undefined, SWI, data abort)
//  and the external IRQ/FIQ lines, and prioritises them per ARM rules. It drains/flushes the pipeline,
//  then in one commit cycle issues the one-hot Exceptions pulse to the CPSR block.
//  In the same commit cycle it issues the vector PC to fetch and the R14_mode link write to the register file.
//  Sits in the controller directly upstream of the CPSR/SPSR block.
// PARAMETERS
//  VECTOR_BASE  32'h0000_0000  base address added to every vector offset
//  SYNC_STAGES  2              flop stages on IrqIn/FiqIn (>=2)
// PORTS
//  clk          in   1   clock
//  reset_n      in   1   asynchronous, active-low reset
//  IrqIn        in   1   external interrupt, level, asynchronous
//  FiqIn        in   1   external fast interrupt, level, asynchronous
//  IrqFiqMask   in   2   CPSR {I,F}; 1 = masked
//  PAbortReq    in   1   prefetch abort on instruction at PAbortPC
//  PAbortPC     in   32  address of aborted instruction
//  UndefReq     in   1   undefined instruction at UndefPC
//  UndefPC      in   32
//  SwiReq       in   1   SWI at SwiPC
//  SwiPC        in   32
//  DAbortReq    in   1   data abort by load/store at DAbortPC
//  DAbortPC     in   32
//  IntPC        in   32  address of oldest uncommitted instruction (interrupt return point)
//  PipeIdle     in   1   pipeline drained after FlushAll; 1 = safe to commit
//  Exceptions   out  6   {FIQ,IRQ,UNDEF,PABT,DABT,SWI}, one-hot, 1-cycle pulse
//  FlushAll     out  1   kill all in-flight instructions
//  StallF       out  1   hold fetch
//  VectorValid  out  1   1-cycle: load VectorPC into PC
//  VectorPC     out  32  VECTOR_BASE + offset
//  LinkWrite    out  1   1-cycle: write LinkAddr to R14 of the new mode
//  LinkAddr     out  32
//  Busy         out  1   FSM not IDLE
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; synchroniser flops 0; captured kind/PC cleared.
//  irq_v = IrqIn synchronised & ~I; fiq_v = FiqIn synchronised & ~F.
//  Priority (high->low): DABT > FIQ > IRQ > PABT > UNDEF > SWI.
//  FSM IDLE: if any request valid, capture the highest kind and its PC in the same edge -> FLUSH.
//    The other requests of that cycle are dropped (flushed instructions re-execute; interrupts are level).
//  FSM FLUSH: FlushAll=1, StallF=1, Busy=1; wait for PipeIdle.
//    DAbortReq while captured kind != DABT replaces the capture (the load/store is older).
//    All other requests are ignored. PipeIdle=1 -> COMMIT.
//  FSM COMMIT (exactly 1 cycle): StallF=1; Exceptions, VectorValid and LinkWrite all pulse; -> IDLE.
//    Not a request source while in COMMIT.
//  Vector offsets: UNDEF 0x04, SWI 0x08, PABT 0x0C, DABT 0x10, IRQ 0x18, FIQ 0x1C.
//  LinkAddr: DABT PC+8; PABT/UNDEF/SWI PC+4; IRQ/FIQ IntPC(captured)+4. 32-bit wrap, no carry out.
//  Min latency: sync request -> Exceptions pulse = 2 cycles (capture, FLUSH with PipeIdle=1, COMMIT).
//    IRQ/FIQ add SYNC_STAGES cycles.
//  Mask change during FLUSH does not cancel a captured IRQ/FIQ.
//  reset_n low mid-sequence: immediate return to IDLE; no pulse is emitted.
// STRUCTURE
//  exc_pkg: typedef enum exc_kind_e {EXC_NONE,SWI,DABT,PABT,UNDEF,IRQ,FIQ};
//    vector-offset localparams; function exc_onehot(kind) returning the 6-bit Exceptions order above.
//  Sub-module exc_sync: SYNC_STAGES flop synchroniser, async active-low reset, instantiated for IRQ and FIQ.
// TESTING
//  UndefReq=1, UndefPC=0x100, PipeIdle=1 -> Exceptions=6'b001000 (pulse), VectorPC=0x04, LinkAddr=0x104.
//  DAbortReq+SwiReq same cycle, DAbortPC=0x200 -> only DABT: 6'b000010, VectorPC=0x10, LinkAddr=0x208.
//  IrqIn=1 with I=1 -> no activity; clear I -> after SYNC_STAGES+2 cycles 6'b010000, VectorPC=0x18.
//  SwiReq captured, PipeIdle=0 for 3 cycles, DAbortReq in cycle 2 -> single DABT commit, no SWI pulse.
//  IrqIn+FiqIn both unmasked -> FIQ first (VectorPC=0x1C); IRQ held high -> IRQ taken after return to IDLE.
//  reset_n low during FLUSH -> Busy=0, FlushAll=0 next; no Exceptions pulse ever issued.

Source files
------------

// File: rtl/exc_pkg.sv
// rtl/exc_pkg.sv - exception kinds, FSM states, vector offsets and helper functions
// Purpose: shared types and pure helpers for exception_ctrl and its users.
// Contents: exc_kind_e, exc_state_e, VEC_OFF_* offsets, exc_onehot, exc_vector_off, exc_link_addr.
package exc_pkg;

    typedef enum logic [2:0] {EXC_NONE, SWI, DABT, PABT, UNDEF, IRQ, FIQ} exc_kind_e;

    typedef enum logic [1:0] {ST_IDLE, ST_FLUSH, ST_COMMIT} exc_state_e;

    localparam logic [31:0] VEC_OFF_UNDEF = 32'h0000_0004;
    localparam logic [31:0] VEC_OFF_SWI   = 32'h0000_0008;
    localparam logic [31:0] VEC_OFF_PABT  = 32'h0000_000C;
    localparam logic [31:0] VEC_OFF_DABT  = 32'h0000_0010;
    localparam logic [31:0] VEC_OFF_IRQ   = 32'h0000_0018;
    localparam logic [31:0] VEC_OFF_FIQ   = 32'h0000_001C;

    // Bit order {FIQ,IRQ,UNDEF,PABT,DABT,SWI}, as consumed by the CPSR block.
    function automatic logic [5:0] exc_onehot(input exc_kind_e kind);
        case (kind)
            FIQ:     return 6'b100000;
            IRQ:     return 6'b010000;
            UNDEF:   return 6'b001000;
            PABT:    return 6'b000100;
            DABT:    return 6'b000010;
            SWI:     return 6'b000001;
            default: return 6'b000000;
        endcase
    endfunction

    function automatic logic [31:0] exc_vector_off(input exc_kind_e kind);
        case (kind)
            UNDEF:   return VEC_OFF_UNDEF;
            SWI:     return VEC_OFF_SWI;
            PABT:    return VEC_OFF_PABT;
            DABT:    return VEC_OFF_DABT;
            IRQ:     return VEC_OFF_IRQ;
            FIQ:     return VEC_OFF_FIQ;
            default: return 32'h0;
        endcase
    endfunction

    // Data aborts return two instructions past the faulting load/store; everything
    // else returns one past the captured PC. Wraps at 32 bits.
    function automatic logic [31:0] exc_link_addr(input exc_kind_e kind, input logic [31:0] pc);
        return pc + ((kind == DABT) ? 32'd8 : 32'd4);
    endfunction

endpackage

// File: rtl/exception_ctrl_if.sv
// rtl/exception_ctrl_if.sv - pipeline/fetch/regfile side bundle of exception_ctrl
// Purpose: groups every non-clock/reset signal of exception_ctrl.
// Modports: slave  = exception_ctrl (takes requests, drives Exceptions/vector/link/flush)
//           master = surrounding controller (drives requests, consumes results)
interface exception_ctrl_if;
    logic        IrqIn;
    logic        FiqIn;
    logic [1:0]  IrqFiqMask;
    logic        PAbortReq;
    logic [31:0] PAbortPC;
    logic        UndefReq;
    logic [31:0] UndefPC;
    logic        SwiReq;
    logic [31:0] SwiPC;
    logic        DAbortReq;
    logic [31:0] DAbortPC;
    logic [31:0] IntPC;
    logic        PipeIdle;
    logic [5:0]  Exceptions;
    logic        FlushAll;
    logic        StallF;
    logic        VectorValid;
    logic [31:0] VectorPC;
    logic        LinkWrite;
    logic [31:0] LinkAddr;
    logic        Busy;

    modport slave (
        input  IrqIn, FiqIn, IrqFiqMask, PAbortReq, PAbortPC, UndefReq, UndefPC,
               SwiReq, SwiPC, DAbortReq, DAbortPC, IntPC, PipeIdle,
        output Exceptions, FlushAll, StallF, VectorValid, VectorPC, LinkWrite, LinkAddr, Busy
    );

    modport master (
        output IrqIn, FiqIn, IrqFiqMask, PAbortReq, PAbortPC, UndefReq, UndefPC,
               SwiReq, SwiPC, DAbortReq, DAbortPC, IntPC, PipeIdle,
        input  Exceptions, FlushAll, StallF, VectorValid, VectorPC, LinkWrite, LinkAddr, Busy
    );
endinterface

// File: rtl/exc_sync.sv
// rtl/exc_sync.sv - multi-flop synchroniser for asynchronous level inputs
// Ports: clk, rst_n (async active-low), d_i (async level), q_o (synchronised level)
module exc_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);
    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];
endmodule

// File: rtl/exception_ctrl.sv
// rtl/exception_ctrl.sv - ARM exception prioritiser, pipeline flush and commit sequencer
// Purpose: picks the highest-priority exception, flushes the pipeline, then in one
//          commit cycle pulses Exceptions, VectorValid/VectorPC and LinkWrite/LinkAddr.
// Ports: clk, reset_n (async active-low), bus (exception_ctrl_if.slave: requests,
//        PCs, mask, PipeIdle in; Exceptions, FlushAll, StallF, vector, link, Busy out)
module exception_ctrl
    import exc_pkg::*;
#(
    parameter logic [31:0] VECTOR_BASE = 32'h0000_0000,
    parameter int          SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    exception_ctrl_if.slave   bus
);
    logic       irq_sync, fiq_sync;
    logic       irq_v, fiq_v;
    exc_kind_e  req_kind;
    logic [31:0] req_pc;

    exc_state_e  state_q;
    exc_kind_e   kind_q, kind_d;
    logic [31:0] pc_q, pc_d;
    logic [5:0]  exc_q;
    logic        flush_q, stall_q, busy_q, vvalid_q, lwrite_q;
    logic [31:0] vpc_q, link_q;

    exc_sync #(.STAGES(SYNC_STAGES)) u_irq_sync (
        .clk(clk), .rst_n(reset_n), .d_i(bus.IrqIn), .q_o(irq_sync)
    );
    exc_sync #(.STAGES(SYNC_STAGES)) u_fiq_sync (
        .clk(clk), .rst_n(reset_n), .d_i(bus.FiqIn), .q_o(fiq_sync)
    );

    // IrqFiqMask is CPSR {I,F}: bit 1 masks IRQ, bit 0 masks FIQ.
    assign irq_v = irq_sync & ~bus.IrqFiqMask[1];
    assign fiq_v = fiq_sync & ~bus.IrqFiqMask[0];

    // Priority DABT > FIQ > IRQ > PABT > UNDEF > SWI; interrupts return to IntPC.
    always_comb begin
        req_kind = EXC_NONE;
        req_pc   = '0;
        if (bus.DAbortReq) begin
            req_kind = DABT;  req_pc = bus.DAbortPC;
        end else if (fiq_v) begin
            req_kind = FIQ;   req_pc = bus.IntPC;
        end else if (irq_v) begin
            req_kind = IRQ;   req_pc = bus.IntPC;
        end else if (bus.PAbortReq) begin
            req_kind = PABT;  req_pc = bus.PAbortPC;
        end else if (bus.UndefReq) begin
            req_kind = UNDEF; req_pc = bus.UndefPC;
        end else if (bus.SwiReq) begin
            req_kind = SWI;   req_pc = bus.SwiPC;
        end
    end

    // While flushing, a data abort belongs to an older load/store than whatever
    // was captured, so it takes over the capture.
    always_comb begin
        kind_d = kind_q;
        pc_d   = pc_q;
        if (bus.DAbortReq && kind_q != DABT) begin
            kind_d = DABT;
            pc_d   = bus.DAbortPC;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            kind_q   <= EXC_NONE;
            pc_q     <= '0;
            exc_q    <= '0;
            flush_q  <= 1'b0;
            stall_q  <= 1'b0;
            busy_q   <= 1'b0;
            vvalid_q <= 1'b0;
            vpc_q    <= '0;
            lwrite_q <= 1'b0;
            link_q   <= '0;
        end else begin
            exc_q    <= '0;
            vvalid_q <= 1'b0;
            lwrite_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req_kind != EXC_NONE) begin
                        state_q <= ST_FLUSH;
                        kind_q  <= req_kind;
                        pc_q    <= req_pc;
                        flush_q <= 1'b1;
                        stall_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                ST_FLUSH: begin
                    kind_q <= kind_d;
                    pc_q   <= pc_d;
                    if (bus.PipeIdle) begin
                        state_q  <= ST_COMMIT;
                        flush_q  <= 1'b0;
                        exc_q    <= exc_onehot(kind_d);
                        vvalid_q <= 1'b1;
                        vpc_q    <= VECTOR_BASE + exc_vector_off(kind_d);
                        lwrite_q <= 1'b1;
                        link_q   <= exc_link_addr(kind_d, pc_d);
                    end
                end
                ST_COMMIT: begin
                    state_q <= ST_IDLE;
                    kind_q  <= EXC_NONE;
                    stall_q <= 1'b0;
                    busy_q  <= 1'b0;
                    vpc_q   <= '0;
                    link_q  <= '0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    flush_q <= 1'b0;
                    stall_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Exceptions  = exc_q;
    assign bus.FlushAll    = flush_q;
    assign bus.StallF      = stall_q;
    assign bus.Busy        = busy_q;
    assign bus.VectorValid = vvalid_q;
    assign bus.VectorPC    = vpc_q;
    assign bus.LinkWrite   = lwrite_q;
    assign bus.LinkAddr    = link_q;
endmodule
